// File: rtl/dbus_pkg.sv
// dbus_pkg: shared types and constants for the data-bus arbiter slice.
//   state_t      - arbiter FSM states (IDLE / ACCESS / RESP)
//   M_CORE/M_LOAD - master indices (core LSU = 0, boot loader / debug = 1)
//   tgt_t        - decoded access target (data RAM or GPIO)
//   ADDR_END1_DEF - default word-index boundary between data RAM and GPIO
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic M_CORE = 1'b0;
  localparam logic M_LOAD = 1'b1;

  typedef enum logic {
    TGT_RAM  = 1'b0,
    TGT_GPIO = 1'b1
  } tgt_t;

  localparam int ADDR_END1_DEF = 4096;

endpackage

// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if: bundles the two master request/response channels and the
// RAM/GPIO bus side of the arbiter.
//   master modport - the environment side: drives requests and read data,
//                    observes grants, read responses, strobes and busy.
//   slave modport  - the arbiter side (dbus_arbiter).
// Parameters: DW data width, AW byte address width.
interface dbus_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic          m0_req_i;
  logic [3:0]    m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_wdata_i;
  logic          m0_gnt_o;
  logic          m0_rvalid_o;
  logic [DW-1:0] m0_rdata_o;

  logic          m1_req_i;
  logic [3:0]    m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_wdata_i;
  logic          m1_gnt_o;
  logic          m1_rvalid_o;
  logic [DW-1:0] m1_rdata_o;

  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic          ram_rd_en_o;
  logic [3:0]    ram_wr_en_o;
  logic          gpio_rd_en_o;
  logic          gpio_wr_en_o;
  logic [DW-1:0] ram_rdata_i;
  logic [DW-1:0] gpio_rdata_i;
  logic          busy_o;

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output ram_rdata_i, gpio_rdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  bus_addr_o, bus_wdata_o, ram_rd_en_o, ram_wr_en_o,
    input  gpio_rd_en_o, gpio_wr_en_o, busy_o
  );

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  ram_rdata_i, gpio_rdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output bus_addr_o, bus_wdata_o, ram_rd_en_o, ram_wr_en_o,
    output gpio_rd_en_o, gpio_wr_en_o, busy_o
  );

endinterface

// File: rtl/dbus_rr_pick.sv
// dbus_rr_pick: combinational two-way pick.
//   req  - request vector {m1, m0}
//   last - master granted last (present only with DBUS_ARB_RR_EN)
//   vld  - at least one master requests
//   win  - chosen master index
// Build option DBUS_ARB_RR_EN: round-robin on a tie (the master not granted
// last wins). Without it, master 0 wins every tie.
module dbus_rr_pick
  import dbus_pkg::*;
(
  input  logic [1:0] req,
`ifdef DBUS_ARB_RR_EN
  input  logic       last,
`endif
  output logic       vld,
  output logic       win
);

  always_comb begin
    vld = |req;
`ifdef DBUS_ARB_RR_EN
    if (&req) win = ~last;
    else      win = req[1] ? M_LOAD : M_CORE;
`else
    win = req[0] ? M_CORE : M_LOAD;
`endif
  end

endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master arbiter/sequencer for the shared data bus
// (data RAM + GPIO). One transaction outstanding at a time.
//   clk_i - clock, rising edge
//   rst_i - synchronous active-high reset
//   bus   - dbus_arbiter_if.slave: master 0 (core LSU) and master 1 (boot
//           loader / debug) request channels, latched bus address/data,
//           RAM and GPIO strobes, RAM/GPIO read data, busy.
// Timing: request sampled in IDLE cycle T; grant + strobes in T+1; read
// data returned with rvalid in T+2. Writes take 2 cycles, reads 3.
// Build option DBUS_ARB_RR_EN: round-robin tie-break with a last-grant
// pointer; otherwise fixed priority with master 0 winning ties.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int ADDR_END1 = ADDR_END1_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dbus_arbiter_if.slave bus
);

  localparam logic [AW-3:0] END_WORD = (AW-2)'(ADDR_END1);

  state_t        state;
  logic          owner;
  tgt_t          tgt;
  logic [3:0]    we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          gnt_q;
  logic          rvalid_q;
  logic          ram_rd_q;
  logic [3:0]    ram_wr_q;
  logic          gpio_rd_q;
  logic          gpio_wr_q;
`ifdef DBUS_ARB_RR_EN
  logic          last_q;
`endif

  logic          pick_vld;
  logic          pick_win;
  logic [AW-1:0] sel_addr;
  logic [3:0]    sel_we;
  logic [DW-1:0] sel_wdata;
  tgt_t          sel_tgt;
  logic [DW-1:0] rdata_sel;

  dbus_rr_pick u_pick (
    .req  ({bus.m1_req_i, bus.m0_req_i}),
`ifdef DBUS_ARB_RR_EN
    .last (last_q),
`endif
    .vld  (pick_vld),
    .win  (pick_win)
  );

  always_comb begin
    sel_addr  = bus.m0_addr_i;
    sel_we    = bus.m0_we_i;
    sel_wdata = bus.m0_wdata_i;
    if (pick_win == M_LOAD) begin
      sel_addr  = bus.m1_addr_i;
      sel_we    = bus.m1_we_i;
      sel_wdata = bus.m1_wdata_i;
    end
    // Word index at or above the boundary lands in GPIO space.
    sel_tgt = (sel_addr[AW-1:2] >= END_WORD) ? TGT_GPIO : TGT_RAM;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      owner     <= M_CORE;
      tgt       <= TGT_RAM;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gnt_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      ram_rd_q  <= 1'b0;
      ram_wr_q  <= '0;
      gpio_rd_q <= 1'b0;
      gpio_wr_q <= 1'b0;
`ifdef DBUS_ARB_RR_EN
      last_q    <= M_LOAD;
`endif
    end else begin
      // Grant, strobes and rvalid are single-cycle pulses.
      gnt_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      ram_rd_q  <= 1'b0;
      ram_wr_q  <= '0;
      gpio_rd_q <= 1'b0;
      gpio_wr_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            owner   <= pick_win;
            tgt     <= sel_tgt;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            gnt_q   <= 1'b1;
            // Strobes are registered here so they line up with the grant.
            if (sel_we != 4'b0000) begin
              if (sel_tgt == TGT_GPIO) gpio_wr_q <= 1'b1;
              else                     ram_wr_q  <= sel_we;
            end else begin
              if (sel_tgt == TGT_GPIO) gpio_rd_q <= 1'b1;
              else                     ram_rd_q  <= 1'b1;
            end
`ifdef DBUS_ARB_RR_EN
            last_q  <= pick_win;
`endif
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q != 4'b0000) begin
            state <= IDLE;
          end else begin
            state    <= RESP;
            rvalid_q <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data arrives from RAM/GPIO one cycle after the strobe, i.e. in RESP.
  assign rdata_sel = (tgt == TGT_GPIO) ? bus.gpio_rdata_i : bus.ram_rdata_i;

  assign bus.m0_gnt_o     = gnt_q & (owner == M_CORE);
  assign bus.m1_gnt_o     = gnt_q & (owner == M_LOAD);
  assign bus.m0_rvalid_o  = rvalid_q & (owner == M_CORE);
  assign bus.m1_rvalid_o  = rvalid_q & (owner == M_LOAD);
  assign bus.m0_rdata_o   = (rvalid_q && owner == M_CORE) ? rdata_sel : '0;
  assign bus.m1_rdata_o   = (rvalid_q && owner == M_LOAD) ? rdata_sel : '0;
  assign bus.bus_addr_o   = addr_q;
  assign bus.bus_wdata_o  = wdata_q;
  assign bus.ram_rd_en_o  = ram_rd_q;
  assign bus.ram_wr_en_o  = ram_wr_q;
  assign bus.gpio_rd_en_o = gpio_rd_q;
  assign bus.gpio_wr_en_o = gpio_wr_q;
  assign bus.busy_o       = (state != IDLE);

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed bench for dbus_arbiter with a transaction-level
// timeline model checked every cycle, plus literal spot checks.
module tb_dbus_arbiter;

  localparam int NCYC = 2048;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   ntot = 0;
  int   nbad = 0;

  dbus_arbiter_if #(.DW(32), .AW(32)) bus ();

  dbus_arbiter #(.DW(32), .AW(32), .ADDR_END1(4096)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #15000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- master drivers ----------------
  op_t q0[$];
  op_t q1[$];
  bit  act0 = 0;
  bit  act1 = 0;

  initial begin
    bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_addr_i = 0; bus.m0_wdata_i = 0;
    bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = 0; bus.m1_wdata_i = 0;
    bus.ram_rdata_i = 0;
    bus.gpio_rdata_i = 32'h0000_005A;
    forever begin
      @(posedge clk); #1;
      bus.ram_rdata_i = 32'hA000_0000 ^ cyc;
      if (act0 && bus.m0_gnt_o) begin void'(q0.pop_front()); act0 = 0; end
      if (!act0 && q0.size() > 0) begin
        bus.m0_addr_i = q0[0].addr; bus.m0_we_i = q0[0].we; bus.m0_wdata_i = q0[0].wdata;
        act0 = 1;
      end
      bus.m0_req_i = act0;
      if (act1 && bus.m1_gnt_o) begin void'(q1.pop_front()); act1 = 0; end
      if (!act1 && q1.size() > 0) begin
        bus.m1_addr_i = q1[0].addr; bus.m1_we_i = q1[0].we; bus.m1_wdata_i = q1[0].wdata;
        act1 = 1;
      end
      bus.m1_req_i = act1;
    end
  end

  // ---------------- timeline model ----------------
  // Expected outputs are scheduled per future cycle at the moment the model
  // decides a transaction; the checker compares them when that cycle comes.
  bit        e_gnt0[NCYC], e_gnt1[NCYC], e_rv0[NCYC], e_rv1[NCYC];
  bit        e_rrd[NCYC], e_grd[NCYC], e_gwr[NCYC], e_busy[NCYC], e_lat[NCYC];
  bit [3:0]  e_rwr[NCYC];
  bit [1:0]  e_src[NCYC];
  bit [31:0] e_addr[NCYC], e_wdata[NCYC];
  bit [31:0] m_addr = 0, m_wdata = 0;
  bit        m_last = 1;
  int        next_free = 0;
  bit        log_en = 0;
  int        glog[$];

  task automatic clr(input int c);
    e_gnt0[c] = 0; e_gnt1[c] = 0; e_rv0[c] = 0; e_rv1[c] = 0; e_rrd[c] = 0;
    e_grd[c] = 0; e_gwr[c] = 0; e_busy[c] = 0; e_lat[c] = 0; e_rwr[c] = 0; e_src[c] = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= NCYC - 4) begin
        $display("FAIL cycle_budget: got=%0d want<%0d", cyc, NCYC - 4);
        $fatal(1, "cycle budget");
      end
      if (cyc >= 1) begin
        bit [31:0] src;
        if (e_lat[cyc]) begin m_addr = e_addr[cyc]; m_wdata = e_wdata[cyc]; end
        src = (e_src[cyc] == 2) ? bus.gpio_rdata_i : (e_src[cyc] == 1) ? bus.ram_rdata_i : 32'h0;
        chk("m0_gnt",    {63'h0, bus.m0_gnt_o},     {63'h0, e_gnt0[cyc]});
        chk("m1_gnt",    {63'h0, bus.m1_gnt_o},     {63'h0, e_gnt1[cyc]});
        chk("m0_rvalid", {63'h0, bus.m0_rvalid_o},  {63'h0, e_rv0[cyc]});
        chk("m1_rvalid", {63'h0, bus.m1_rvalid_o},  {63'h0, e_rv1[cyc]});
        chk("m0_rdata",  {32'h0, bus.m0_rdata_o},   {32'h0, (e_rv0[cyc] ? src : 32'h0)});
        chk("m1_rdata",  {32'h0, bus.m1_rdata_o},   {32'h0, (e_rv1[cyc] ? src : 32'h0)});
        chk("ram_rd",    {63'h0, bus.ram_rd_en_o},  {63'h0, e_rrd[cyc]});
        chk("ram_wr",    {60'h0, bus.ram_wr_en_o},  {60'h0, e_rwr[cyc]});
        chk("gpio_rd",   {63'h0, bus.gpio_rd_en_o}, {63'h0, e_grd[cyc]});
        chk("gpio_wr",   {63'h0, bus.gpio_wr_en_o}, {63'h0, e_gwr[cyc]});
        chk("busy",      {63'h0, bus.busy_o},       {63'h0, e_busy[cyc]});
        chk("bus_addr",  {32'h0, bus.bus_addr_o},   {32'h0, m_addr});
        chk("bus_wdata", {32'h0, bus.bus_wdata_o},  {32'h0, m_wdata});
        if (log_en && bus.m0_gnt_o) glog.push_back(0);
        if (log_en && bus.m1_gnt_o) glog.push_back(1);
      end
      if (rst) begin
        clr(cyc + 1); clr(cyc + 2);
        e_lat[cyc + 1] = 1; e_addr[cyc + 1] = 0; e_wdata[cyc + 1] = 0;
        next_free = cyc + 1;
        m_last = 1;
      end else if (cyc >= next_free && (bus.m0_req_i || bus.m1_req_i)) begin
        bit          w;
        bit [31:0]   a, d;
        bit [3:0]    we;
        bit          gp;
        if (bus.m0_req_i && bus.m1_req_i) begin
`ifdef DBUS_ARB_RR_EN
          w = !m_last;
`else
          w = 0;
`endif
        end else begin
          w = bus.m1_req_i;
        end
        m_last = w;
        a  = w ? bus.m1_addr_i : bus.m0_addr_i;
        d  = w ? bus.m1_wdata_i : bus.m0_wdata_i;
        we = w ? bus.m1_we_i : bus.m0_we_i;
        gp = (a / 4) >= 4096;
        e_gnt0[cyc + 1] = !w; e_gnt1[cyc + 1] = w; e_busy[cyc + 1] = 1;
        e_lat[cyc + 1] = 1; e_addr[cyc + 1] = a; e_wdata[cyc + 1] = d;
        if (we != 0) begin
          if (gp) e_gwr[cyc + 1] = 1; else e_rwr[cyc + 1] = we;
          next_free = cyc + 2;
        end else begin
          if (gp) e_grd[cyc + 1] = 1; else e_rrd[cyc + 1] = 1;
          e_busy[cyc + 2] = 1;
          e_src[cyc + 2] = gp ? 2'd2 : 2'd1;
          if (w) e_rv1[cyc + 2] = 1; else e_rv0[cyc + 2] = 1;
          next_free = cyc + 3;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic push(input int m, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    op_t o;
    o.addr = a; o.we = we; o.wdata = d;
    if (m == 0) q0.push_back(o); else q1.push_back(o);
  endtask

  task automatic wait_gnt(input int m, output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if ((m == 0 && bus.m0_gnt_o) || (m == 1 && bus.m1_gnt_o)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      ntot++; nbad++;
      $display("FAIL wait_gnt_m%0d: got=timeout want=grant", m);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (q0.size() == 0 && q1.size() == 0 && !act0 && !act1 && !bus.busy_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      ntot++; nbad++;
      $display("FAIL wait_idle: got=busy want=idle");
    end
    @(posedge clk); #2;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  initial begin
    int g;
    int exp_seq[8];
`ifdef DBUS_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", {63'h0, bus.busy_o}, 64'h0);
    chk("rst_addr", {32'h0, bus.bus_addr_o}, 64'h0);
    chk("rst_gnt", {62'h0, bus.m1_gnt_o, bus.m0_gnt_o}, 64'h0);
    rst = 0;
    step();

    // m0 RAM write
    push(0, 32'h10, 4'b1111, 32'hDEADBEEF);
    wait_gnt(0, g);
    chk("wr_ram_wr", {60'h0, bus.ram_wr_en_o}, 64'hF);
    chk("wr_addr", {32'h0, bus.bus_addr_o}, 64'h10);
    chk("wr_wdata", {32'h0, bus.bus_wdata_o}, 64'hDEADBEEF);
    chk("wr_gpio", {62'h0, bus.gpio_wr_en_o, bus.gpio_rd_en_o}, 64'h0);
    wait_idle();

    // m1 GPIO read at the first GPIO word
    push(1, 32'h4000, 4'b0000, 32'h0);
    wait_gnt(1, g);
    chk("rd_gpio_rd", {63'h0, bus.gpio_rd_en_o}, 64'h1);
    chk("rd_ram_rd", {63'h0, bus.ram_rd_en_o}, 64'h0);
    step();
    chk("rd_m1_rvalid", {63'h0, bus.m1_rvalid_o}, 64'h1);
    chk("rd_m1_rdata", {32'h0, bus.m1_rdata_o}, 64'h5A);
    chk("rd_m0_rdata", {32'h0, bus.m0_rdata_o}, 64'h0);
    wait_idle();

    // Address boundary
    push(0, 32'h3FFC, 4'b0000, 32'h0);
    wait_gnt(0, g);
    chk("bnd_ram_rd", {62'h0, bus.ram_rd_en_o, bus.gpio_rd_en_o}, 64'h2);
    wait_idle();
    push(0, 32'h4000, 4'b0000, 32'h0);
    wait_gnt(0, g);
    chk("bnd_gpio_rd", {62'h0, bus.ram_rd_en_o, bus.gpio_rd_en_o}, 64'h1);
    wait_idle();
    push(0, 32'h4004, 4'b0010, 32'h1234_5678);
    wait_gnt(0, g);
    chk("bnd_gpio_wr", {63'h0, bus.gpio_wr_en_o}, 64'h1);
    chk("bnd_ram_wr", {60'h0, bus.ram_wr_en_o}, 64'h0);
    wait_idle();

    // Back-to-back m0 read then write
    push(0, 32'h20, 4'b0000, 32'h0);
    push(0, 32'h24, 4'b0011, 32'hCAFE_F00D);
    wait_gnt(0, g);
    chk("b2b_busy1", {63'h0, bus.busy_o}, 64'h1);
    step();
    chk("b2b_rvalid", {63'h0, bus.m0_rvalid_o}, 64'h1);
    step();
    chk("b2b_busy_low", {63'h0, bus.busy_o}, 64'h0);
    chk("b2b_no_gnt", {63'h0, bus.m0_gnt_o}, 64'h0);
    step();
    chk("b2b_gnt2", {63'h0, bus.m0_gnt_o}, 64'h1);
    chk("b2b_ram_wr", {60'h0, bus.ram_wr_en_o}, 64'h3);
    wait_idle();

    // Last grant to m1 so the first tie goes to m0 under round-robin
    push(1, 32'h4008, 4'b0001, 32'h77);
    wait_idle();

    // Both masters request continuously, four writes each
    glog.delete();
    log_en = 1;
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h100 + 32'(i * 4), 4'b1111, 32'h0A00 + 32'(i));
      push(1, 32'h200 + 32'(i * 4), 4'b1111, 32'h0B00 + 32'(i));
    end
    wait_idle();
    log_en = 0;
    chk("arb_count", 64'(glog.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < glog.size()) chk($sformatf("arb_order%0d", i), 64'(glog[i]), 64'(exp_seq[i]));
    end

    // Reset held two cycles in the middle of a read
    push(0, 32'h30, 4'b0000, 32'h0);
    wait_gnt(0, g);
    rst = 1;
    step();
    chk("mid_rst_busy", {63'h0, bus.busy_o}, 64'h0);
    chk("mid_rst_rvalid", {63'h0, bus.m0_rvalid_o}, 64'h0);
    chk("mid_rst_addr", {32'h0, bus.bus_addr_o}, 64'h0);
    step();
    rst = 0;
    chk("mid_rst_busy2", {63'h0, bus.busy_o}, 64'h0);
    chk("mid_rst_rdata", {32'h0, bus.m0_rdata_o}, 64'h0);
    step();
    push(0, 32'h40, 4'b0000, 32'h0);
    wait_gnt(0, g);
    chk("post_rst_ram_rd", {63'h0, bus.ram_rd_en_o}, 64'h1);
    chk("post_rst_addr", {32'h0, bus.bus_addr_o}, 64'h40);
    step();
    chk("post_rst_rvalid", {63'h0, bus.m0_rvalid_o}, 64'h1);
    chk("post_rst_rdata", {32'h0, bus.m0_rdata_o}, {32'h0, 32'hA000_0000 ^ cyc});
    wait_idle();

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter and sequencer for the shared data bus (data RAM + GPIO) of the 5-stage core. It accepts load/store requests from the core LSU (master 0) and the boot loader / debug port (master 1), and grants one of them per transaction. It drives the selected access onto the bus with the data-RAM/GPIO address split, then returns read data to the granted master. A single transaction is outstanding at a time.

## Interface
- DW, 32, data width
- AW, 32, byte address width
- ADDR_END1, 4096, word-index boundary; addr[AW-1:2] >= ADDR_END1 selects GPIO, else data RAM
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- mN_req_i  in  1  request from master N (N = 0, 1); held high until mN_gnt_o
- mN_we_i  in  4  byte write enables; 4'b0000 = read
- mN_addr_i  in  AW  byte address
- mN_wdata_i  in  DW  write data
- mN_gnt_o  out  1  one-cycle pulse: request accepted, master may drop or change request
- mN_rvalid_o  out  1  one-cycle pulse: read data valid (reads only)
- mN_rdata_o  out  DW  read data, valid with mN_rvalid_o, else 0
- bus_addr_o  out  AW  latched address to RAM/GPIO
- bus_wdata_o  out  DW  latched write data
- ram_rd_en_o  out  1  data-RAM read strobe
- ram_wr_en_o  out  4  data-RAM byte write strobes
- gpio_rd_en_o  out  1  GPIO read strobe
- gpio_wr_en_o  out  1  GPIO write strobe (OR of byte enables)
- ram_rdata_i  in  DW  RAM read data, one cycle after ram_rd_en_o
- gpio_rdata_i  in  DW  GPIO read data, one cycle after gpio_rd_en_o
- busy_o  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any mN_req_i high, pick winner, latch its addr/we/wdata, latched master index and target (RAM/GPIO); next state ACCESS. No request: stay IDLE.
- ACCESS: pulse winner's gnt; drive exactly one strobe group from latched fields. Write (we != 0): RAM gets we, or GPIO gets |we; next IDLE. Read: RAM or GPIO rd_en; next RESP.
- RESP: select ram_rdata_i or gpio_rdata_i by latched target; pulse winner's rvalid and drive its rdata; next IDLE.
- Arbitration (both requesting): per Configuration. Single requester always wins.
- Loser's request is untouched and re-arbitrated in the next IDLE.
- Reset (any state, including mid-transaction): state IDLE, all outputs 0, latched fields 0, last-grant pointer = master 1 (so master 0 wins first tie). In-flight access is dropped; no rvalid issued.
- Non-granted master's gnt/rvalid/rdata stay 0 at all times.

## Timing
- Request seen in IDLE cycle T -> gnt + strobes in T+1.
- Write: complete at T+1; next arbitration at T+2 (2 cycles/write).
- Read: rd_en at T+1, rvalid + rdata at T+2; next arbitration at T+3 (3 cycles/read).
- bus_addr_o/bus_wdata_o hold latched values from T+1 until the next latch; strobes are single-cycle.
- Requests arriving in ACCESS/RESP are not sampled until IDLE.

## Configuration
- DBUS_ARB_RR_EN defined: round-robin; on tie, grant the master not granted last; pointer updates on every grant.
- Undefined: fixed priority; master 0 (core) always wins ties; pointer logic removed.

## Structure
- Package dbus_pkg: FSM state enum (IDLE/ACCESS/RESP), master index constants M_CORE=0 / M_LOAD=1, target enum (TGT_RAM/TGT_GPIO), default ADDR_END1.
- Sub-module dbus_rr_pick: combinational 2-way pick from req vector and last-grant pointer (fixed priority when DBUS_ARB_RR_EN undefined).

## Test plan
- Reset: hold rst_i 2 cycles mid-read -> all outputs 0, busy_o 0, no rvalid; next m0 read proceeds normally.
- m0 write addr 0x10, we 4'b1111, wdata 0xDEADBEEF -> T+1: m0_gnt_o, ram_wr_en_o=4'b1111, bus_addr_o=0x10; gpio strobes 0.
- m1 read addr 0x4000 (word 4096), gpio_rdata_i=0x5A -> T+1 gpio_rd_en_o, T+2 m1_rvalid_o, m1_rdata_o=0x5A; RAM strobes 0.
- Boundary: read 0x3FFC -> ram_rd_en_o; read 0x4000 -> gpio_rd_en_o; write we 4'b0010 to 0x4004 -> gpio_wr_en_o=1.
- Both request continuously, 4 writes each: RR_EN -> grants m0,m1,m0,m1...; without -> m0 four times, then m1.
- Back-to-back m0 read then write -> gnt at T+1 and T+4, rvalid at T+2, busy_o low only at T+3.
